// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported memory between the CPU
// instruction-fetch port and the data port. Data requests have fixed priority.
// A starvation counter forces a fetch grant after STARVE_LIMIT consecutive
// data wins while a fetch waits. One transaction is outstanding at a time.
// A memory that never acknowledges is aborted after TIMEOUT busy cycles.
//
// Handshake: a requester raises *_req with stable address/data and keeps them
// stable until its *_ready pulses for exactly one cycle. rdata/err are valid in
// that cycle. Toward memory, mem_req stays high with stable mem_addr,
// mem_wdata and mem_wen until the cycle mem_ack is seen. mem_rdata is valid in
// the same cycle as mem_ack. An ack outside BUSY is ignored.
module unified_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [3:0]        dm_wen,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wen,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [TO_W-1:0] TO_LAST    = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;
  localparam logic [DATA_W-1:0] ABORT_WORD = DATA_W'(32'hDEADBEEF);

  state_e            state_q, state_d;
  logic              grant_data_q, grant_data_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic [TO_W-1:0]   tmo_q, tmo_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wen_q, mem_wen_d;
  logic              if_ready_q, if_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              if_err_q, if_err_d;
  logic              dm_ready_q, dm_ready_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              dm_err_q, dm_err_d;

  logic              pick_data;
  logic              fin;
  logic              fin_err;
  logic [DATA_W-1:0] fin_rdata;

  // Next-state, arbitration, timeout and response formation.
  always_comb begin
    state_d      = state_q;
    grant_data_d = grant_data_q;
    starve_d     = starve_q;
    tmo_d        = tmo_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wen_d    = mem_wen_q;
    if_ready_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    if_err_d     = 1'b0;
    dm_ready_d   = 1'b0;
    dm_rdata_d   = dm_rdata_q;
    dm_err_d     = 1'b0;
    pick_data    = 1'b0;
    fin          = 1'b0;
    fin_err      = 1'b0;
    fin_rdata    = '0;

    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          // Data wins unless a waiting fetch has been passed over STARVE_LIMIT times.
          pick_data    = dm_req && !(if_req && (starve_q == STARVE_MAX));
          grant_data_d = pick_data;
          state_d      = BUSY;
          tmo_d        = '0;
          if (pick_data) begin
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            mem_wen_d   = dm_wen;
            if (if_req && (starve_q != STARVE_MAX)) begin
              starve_d = starve_q + SC_W'(1);
            end
          end else begin
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_wen_d   = 4'b0000;
            starve_d    = '0;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          fin       = 1'b1;
          fin_rdata = mem_rdata;
          state_d   = RESP;
        end else if ((TIMEOUT != 0) && (tmo_q == TO_LAST)) begin
          fin       = 1'b1;
          fin_err   = 1'b1;
          fin_rdata = ABORT_WORD;
          state_d   = RESP;
        end else if (TIMEOUT != 0) begin
          tmo_d = tmo_q + TO_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The response registers of the granted side load as BUSY completes.
    if (fin) begin
      if (grant_data_q) begin
        dm_ready_d = 1'b1;
        dm_rdata_d = fin_rdata;
        dm_err_d   = fin_err;
      end else begin
        if_ready_d = 1'b1;
        if_rdata_d = fin_rdata;
        if_err_d   = fin_err;
      end
    end

    mem_req_d = (state_d == BUSY);
  end

  // State and output registers; reset discards any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_data_q <= 1'b0;
      starve_q     <= '0;
      tmo_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wen_q    <= 4'b0000;
      if_ready_q   <= 1'b0;
      if_rdata_q   <= '0;
      if_err_q     <= 1'b0;
      dm_ready_q   <= 1'b0;
      dm_rdata_q   <= '0;
      dm_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_data_q <= grant_data_d;
      starve_q     <= starve_d;
      tmo_q        <= tmo_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wen_q    <= mem_wen_d;
      if_ready_q   <= if_ready_d;
      if_rdata_q   <= if_rdata_d;
      if_err_q     <= if_err_d;
      dm_ready_q   <= dm_ready_d;
      dm_rdata_q   <= dm_rdata_d;
      dm_err_q     <= dm_err_d;
    end
  end

  assign if_ready  = if_ready_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign dm_ready  = dm_ready_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_err    = dm_err_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wen   = mem_wen_q;
  assign busy      = (state_q != IDLE);

endmodule
